keycode_event_queue: RTL and testbench
======================================

KEYCODE_EVENT_QUEUE -- requirements
Module: keycode_event_queue

Interface
REQ-001 Parameter DEPTH, default 8, event FIFO entries; power of two, 2..64.
REQ-002 clk_clk  input  1  system clock; the only clock.
REQ-003 reset_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 keycode  input  8  current USB HID keycode from the SoC keycode PIO, synchronous to clk_clk; 0x00 means no key.
REQ-005 evt_valid  output  1  head-of-queue event present.
REQ-006 evt_press  output  1  head event type: 1 press, 0 release.
REQ-007 evt_code  output  8  head event keycode.
REQ-008 evt_ready  input  1  consumer accepts head event.
REQ-009 count  output  log2(DEPTH)+1  events currently queued.
REQ-010 overflow  output  1  sticky: an event was required while the queue was full.
REQ-011 clr_overflow  input  1  clears overflow.

Function
REQ-012 The block SHALL hold a tracked-key register cur_key, reset 0x00.
REQ-013 Keycodes 0x01-0x03 (USB error/rollover) SHALL be treated as equal to cur_key, generating no event.
REQ-014 Each cycle, if keycode != cur_key and cur_key != 0x00, the block SHALL request push of {release, cur_key} and set cur_key to 0x00 on acceptance.
REQ-015 Else if keycode != cur_key and cur_key == 0x00, the block SHALL request push of {press, keycode} and set cur_key to keycode on acceptance.
REQ-016 At most one event SHALL be pushed per cycle; a direct A->B keycode change SHALL yield release A then press B on consecutive cycles.
REQ-017 A push SHALL be accepted only when count < DEPTH at the start of the cycle; a simultaneous pop does not free a slot for the same cycle.
REQ-018 When a push is requested but refused, cur_key SHALL be held, overflow SHALL be set, and the request SHALL be retried every cycle.
REQ-019 Transient keycodes that appear and vanish while stalled SHALL be lost without further effect.
REQ-020 A pop SHALL occur when evt_valid && evt_ready; evt_ready with the queue empty SHALL be ignored.
REQ-021 evt_valid, evt_press, evt_code SHALL be driven from the FIFO head register; the first event SHALL appear one cycle after the push cycle.
REQ-022 count SHALL increment on push only, decrement on pop only, and hold on push plus pop; it never exceeds DEPTH and never wraps below 0.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 evt_press/evt_code SHALL hold while evt_valid && !evt_ready.
REQ-025 overflow SHALL be cleared by clr_overflow; a set and a clear in the same cycle SHALL leave it set.

Reset
REQ-026 Asserting reset_reset_n low SHALL immediately force cur_key=0x00, pointers=0, count=0, evt_valid=0, evt_press=0, evt_code=0x00, overflow=0.
REQ-027 Reset mid-operation SHALL discard all queued events.
REQ-028 After reset release, a nonzero keycode held through reset SHALL produce a press event.

Structure
REQ-029 Package keycode_pkg SHALL hold: the event struct typedef {press, code[7:0]}, KC_NONE=0x00, KC_ERR_LO=0x01, KC_ERR_HI=0x03, and default DEPTH.
REQ-030 A single sub-module sync_fifo (parameterised width/depth, valid/ready read side, full/count) SHALL hold the storage; the event-generation FSM sits in the top.

Verification
REQ-031 keycode 0x00->0x04, evt_ready=1 -> one event {press,0x04}; count returns to 0.
REQ-032 keycode 0x04->0x16 in one cycle -> {release,0x04} then {press,0x16} on consecutive pushes.
REQ-033 keycode 0x04->0x01->0x04 -> only the initial press; no event for 0x01.
REQ-034 evt_ready=0, toggle keycode 0x00/0x1A on 10 distinct changes with DEPTH=8 -> count=8, overflow=1, first 8 events in order; clr_overflow clears the flag; draining resumes pending pushes.
REQ-035 Queue full, pop and required push in the same cycle -> push refused, count=7 next cycle, push accepted the cycle after.
REQ-036 Reset asserted with count=5 and keycode=0x2C -> outputs zero asynchronously; after release a single {press,0x2C} is queued.

Source files
------------

// File: rtl/keycode_pkg.sv
// Shared types and constants for the keycode event queue.
package keycode_pkg;

    localparam int KC_DEPTH_DEFAULT = 8;

    localparam logic [7:0] KC_NONE   = 8'h00;
    localparam logic [7:0] KC_ERR_LO = 8'h01;
    localparam logic [7:0] KC_ERR_HI = 8'h03;

    // One queued key event: press=1 for key-down, press=0 for key-up.
    typedef struct packed {
        logic       press;
        logic [7:0] code;
    } kc_event_t;

    // USB HID error/rollover codes carry no information about which key is held.
    function automatic logic kc_is_rollover(input logic [7:0] kc);
        return (kc >= KC_ERR_LO) && (kc <= KC_ERR_HI);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO whose head entry is presented from registers (valid/ready read side).
module sync_fifo #(
    parameter  int DATA_W = 9,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              full_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              rd_ready_i,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              head_valid_q, head_valid_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic              push, pop;

    // Fullness is judged on the count at the start of the cycle, so a pop never frees a slot early.
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign push       = wr_valid_i && !full_o;
    assign pop        = head_valid_q && rd_ready_i;
    assign rd_valid_o = head_valid_q;
    assign rd_data_o  = head_data_q;
    assign count_o    = count_q;

    // Pointer/count update and look-ahead of the next head entry.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        head_data_d  = head_data_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        head_valid_d = (count_d != '0);
        // The entry being written becomes head when it lands on the new read slot.
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) head_data_d = wr_data_i;
            else                                head_data_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Control and head registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end

endmodule

// File: rtl/keycode_event_queue.sv
// Turns a level keycode stream into press/release events queued for a consumer.
module keycode_event_queue
    import keycode_pkg::*;
#(
    parameter  int DEPTH = KC_DEPTH_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [7:0]       keycode,
    output logic             evt_valid,
    output logic             evt_press,
    output logic [7:0]       evt_code,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             clr_overflow
);

    logic [7:0] cur_key_q, cur_key_d;
    logic       overflow_q, overflow_d;
    logic [7:0] kc_eff;
    logic       push_req;
    logic       fifo_full;
    kc_event_t  push_evt;
    kc_event_t  head_evt;

    // Event generation: release the tracked key first, then press the new one on a later cycle.
    always_comb begin
        kc_eff = keycode;
        if (kc_is_rollover(keycode)) kc_eff = cur_key_q;
        push_req       = (kc_eff != cur_key_q);
        push_evt.press = (cur_key_q == KC_NONE);
        push_evt.code  = (cur_key_q == KC_NONE) ? kc_eff : cur_key_q;
        cur_key_d      = cur_key_q;
        // The tracked key only moves once the event is in the queue; a refused push is retried.
        if (push_req && !fifo_full) cur_key_d = (cur_key_q == KC_NONE) ? kc_eff : KC_NONE;
        overflow_d = overflow_q;
        if (push_req && fifo_full) overflow_d = 1'b1;
        else if (clr_overflow)     overflow_d = 1'b0;
    end

    // Tracked key and sticky overflow flag.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cur_key_q  <= KC_NONE;
            overflow_q <= 1'b0;
        end else begin
            cur_key_q  <= cur_key_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .DATA_W ($bits(kc_event_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i      (clk_clk),
        .rst_ni     (reset_reset_n),
        .wr_valid_i (push_req),
        .wr_data_i  (push_evt),
        .full_o     (fifo_full),
        .rd_valid_o (evt_valid),
        .rd_data_o  (head_evt),
        .rd_ready_i (evt_ready),
        .count_o    (count)
    );

    assign evt_press = head_evt.press;
    assign evt_code  = head_evt.code;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keycode_event_queue.sv
module tb_keycode_event_queue;

    localparam int DEPTH = 8;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic [7:0] keycode;
    logic       evt_valid;
    logic       evt_press;
    logic [7:0] evt_code;
    logic       evt_ready;
    logic [3:0] count;
    logic       overflow;
    logic       clr_overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: list of queued events {press, code}, the held key and the sticky flag.
    logic [8:0] mq [$];
    logic [7:0] m_cur;
    bit         m_ovf;

    always #5 clk_clk = ~clk_clk;

    keycode_event_queue #(.DEPTH(DEPTH)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .keycode       (keycode),
        .evt_valid     (evt_valid),
        .evt_press     (evt_press),
        .evt_code      (evt_code),
        .evt_ready     (evt_ready),
        .count         (count),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cur = 8'h00;
        m_ovf = 1'b0;
    endtask

    // One clock edge of the key-event rules applied to the abstract queue.
    task automatic model_edge(input logic [7:0] kc, input logic rdy, input logic clr);
        bit         do_pop;
        bit         was_full;
        bit         req;
        logic [7:0] k;
        logic [8:0] ev;
        do_pop   = (mq.size() > 0) && rdy;
        was_full = (mq.size() == DEPTH);
        k        = (kc >= 8'h01 && kc <= 8'h03) ? m_cur : kc;
        req      = (k != m_cur);
        ev       = (m_cur != 8'h00) ? {1'b0, m_cur} : {1'b1, k};
        if (do_pop) void'(mq.pop_front());
        if (req && !was_full) begin
            mq.push_back(ev);
            m_cur = (m_cur != 8'h00) ? 8'h00 : k;
        end
        if (req && was_full) m_ovf = 1'b1;
        else if (clr)        m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        check("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
        check("count", 32'(count), 32'(mq.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) begin
            check("evt_press", 32'(evt_press), 32'(mq[0][8]));
            check("evt_code", 32'(evt_code), 32'(mq[0][7:0]));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(evt_valid), 32'(0));
        check({tag, "_press"}, 32'(evt_press), 32'(0));
        check({tag, "_code"}, 32'(evt_code), 32'(0));
        check({tag, "_count"}, 32'(count), 32'(0));
        check({tag, "_overflow"}, 32'(overflow), 32'(0));
    endtask

    task automatic cycle(input logic [7:0] kc, input logic rdy, input logic clr);
        keycode      = kc;
        evt_ready    = rdy;
        clr_overflow = clr;
        @(posedge clk_clk);
        model_edge(kc, rdy, clr);
        #1 check_outputs();
    endtask

    initial begin
        logic [7:0] kc_tab [8];
        logic [7:0] kc_r;
        logic       rdy_r;
        kc_tab = '{8'h00, 8'h01, 8'h03, 8'h04, 8'h16, 8'h1A, 8'h2C, 8'h00};

        reset_reset_n = 1'b0;
        keycode       = 8'h00;
        evt_ready     = 1'b0;
        clr_overflow  = 1'b0;
        model_reset();
        #2 check_zero("reset");
        repeat (2) @(posedge clk_clk);
        #3 reset_reset_n = 1'b1;

        // Single press, consumed immediately.
        cycle(8'h04, 1'b1, 1'b0);
        check("press04_code", 32'(evt_code), 32'h04);
        cycle(8'h04, 1'b1, 1'b0);
        check("press04_drained", 32'(count), 32'(0));

        // Direct change 0x04 -> 0x16: release then press on consecutive cycles.
        cycle(8'h16, 1'b1, 1'b0);
        check("rel04_press", 32'(evt_press), 32'(0));
        cycle(8'h16, 1'b1, 1'b0);
        check("press16_code", 32'(evt_code), 32'h16);
        cycle(8'h16, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b0);

        // Rollover code between presses of the same key generates nothing.
        cycle(8'h04, 1'b0, 1'b0);
        cycle(8'h01, 1'b0, 1'b0);
        cycle(8'h04, 1'b0, 1'b0);
        check("rollover_count", 32'(count), 32'(1));
        cycle(8'h04, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b0);

        // Fill to DEPTH with a stalled consumer, leaving a press pending.
        for (int i = 0; i < 11; i++) cycle((i % 2 == 0) ? 8'h1A : 8'h00, 1'b0, 1'b0);
        check("fill_count", 32'(count), 32'(8));
        check("fill_overflow", 32'(overflow), 32'(1));
        // Clear while the refused push re-sets the flag: stays set.
        cycle(8'h1A, 1'b0, 1'b1);
        check("clr_vs_set", 32'(overflow), 32'(1));
        // Pop with a push pending: push refused this cycle.
        cycle(8'h1A, 1'b1, 1'b0);
        check("pop_full_count", 32'(count), 32'(7));
        cycle(8'h1A, 1'b0, 1'b0);
        check("retry_count", 32'(count), 32'(8));
        cycle(8'h1A, 1'b0, 1'b1);
        check("clr_overflow", 32'(overflow), 32'(0));
        for (int i = 0; i < 9; i++) cycle(8'h1A, 1'b1, 1'b0);
        check("drained", 32'(count), 32'(0));

        // Randomised traffic against the model.
        kc_r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                int r;
                r = int'($urandom_range(0, 9));
                kc_r = (r < 8) ? kc_tab[r] : 8'($urandom_range(0, 255));
            end
            rdy_r = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(kc_r, rdy_r, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 12; i++) cycle(8'h00, 1'b1, 1'b1);
        check("idle_count", 32'(count), 32'(0));

        // Reset with five events queued and a key held.
        for (int i = 0; i < 5; i++) cycle((i % 2 == 0) ? 8'h2C : 8'h00, 1'b0, 1'b0);
        check("pre_reset_count", 32'(count), 32'(5));
        #3 reset_reset_n = 1'b0;
        model_reset();
        #1 check_zero("async_reset");
        @(posedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        cycle(8'h2C, 1'b0, 1'b0);
        check("post_reset_code", 32'(evt_code), 32'h2C);
        cycle(8'h2C, 1'b0, 1'b0);
        check("post_reset_count", 32'(count), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
